// File: rtl/prototype_trainer_pkg.sv
// Shared HDC definitions for the prototype trainer: geometry defaults,
// class label encoding and the trainer FSM state type.
package prototype_trainer_pkg;

  localparam int DIMENSIONS_DEFAULT  = 10000;
  localparam int MAX_SAMPLES_DEFAULT = 255;

  localparam logic LABEL_NS = 1'b0;
  localparam logic LABEL_S  = 1'b1;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    FINALIZE = 2'd1,
    HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/prototype_trainer_if.sv
// Training-sample stream into the prototype trainer.
// Handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
// the source holds sample_hv/sample_label stable while sample_valid is high, and
// sample_ready does not depend on sample_valid.
interface prototype_trainer_if
  import prototype_trainer_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEFAULT
);

  logic                  sample_valid;
  logic                  sample_ready;
  logic [DIMENSIONS-1:0] sample_hv;
  logic                  sample_label;

  modport master (
    output sample_valid,
    output sample_hv,
    output sample_label,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_hv,
    input  sample_label,
    output sample_ready
  );

endinterface

// File: rtl/prototype_trainer_bundle_counter.sv
// One class's bundling accumulator: a per-dimension set-bit counter array, the
// class sample count, and the strict-majority threshold of the counters.
module bundle_counter
  import prototype_trainer_pkg::*;
#(
  parameter int  DIMENSIONS  = DIMENSIONS_DEFAULT,
  parameter int  MAX_SAMPLES = MAX_SAMPLES_DEFAULT,
  localparam int CW          = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  acc_en,
  input  logic [DIMENSIONS-1:0] hv,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic [DIMENSIONS-1:0] majority
);

  logic [CW-1:0] cnt_q [DIMENSIONS];
  logic [CW-1:0] count_q;
  logic          acc;

  assign full  = (count_q == CW'(MAX_SAMPLES));
  assign count = count_q;
  // Counters cannot wrap: each is bounded by count_q, which stops at MAX_SAMPLES.
  assign acc   = acc_en && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= '0;
    end else if (clear) begin
      count_q <= '0;
      for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= '0;
    end else if (acc) begin
      count_q <= count_q + 1'b1;
      for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= cnt_q[i] + CW'(hv[i]);
    end
  end

  // Strict majority: ties and an empty class both give 0.
  always_comb begin
    majority = '0;
    for (int i = 0; i < DIMENSIONS; i++)
      majority[i] = ({cnt_q[i], 1'b0} > {1'b0, count_q});
  end

endmodule

// File: rtl/prototype_trainer.sv
// HDC prototype trainer: bundles labelled training hypervectors per class and
// thresholds them into non-seizure / seizure prototypes on request.
module prototype_trainer
  import prototype_trainer_pkg::*;
#(
  parameter int  DIMENSIONS  = DIMENSIONS_DEFAULT,
  parameter int  MAX_SAMPLES = MAX_SAMPLES_DEFAULT,
  localparam int CW          = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  prototype_trainer_if.slave    smp,
  input  logic                  clear,
  input  logic                  finalize,
  output logic                  done,
  output logic [DIMENSIONS-1:0] ns_hv,
  output logic [DIMENSIONS-1:0] s_hv,
  output logic [CW-1:0]         ns_count,
  output logic [CW-1:0]         s_count,
  output logic                  overflow,
  output state_t                state_dbg
);

  state_t                state_q, state_d;
  logic                  accept;
  logic                  ns_acc, s_acc;
  logic                  ns_full, s_full;
  logic [DIMENSIONS-1:0] ns_maj, s_maj;

  assign smp.sample_ready = (state_q == ACCUM);
  assign state_dbg        = state_q;
  assign done             = (state_q == HOLD);

  // clear discards any sample offered in the same cycle.
  assign accept = smp.sample_valid && smp.sample_ready && !clear;
  assign ns_acc = accept && (smp.sample_label == LABEL_NS);
  assign s_acc  = accept && (smp.sample_label == LABEL_S);

  bundle_counter #(.DIMENSIONS(DIMENSIONS), .MAX_SAMPLES(MAX_SAMPLES)) u_ns (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .acc_en   (ns_acc),
    .hv       (smp.sample_hv),
    .count    (ns_count),
    .full     (ns_full),
    .majority (ns_maj)
  );

  bundle_counter #(.DIMENSIONS(DIMENSIONS), .MAX_SAMPLES(MAX_SAMPLES)) u_s (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .acc_en   (s_acc),
    .hv       (smp.sample_hv),
    .count    (s_count),
    .full     (s_full),
    .majority (s_maj)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:    if (finalize) state_d = FINALIZE;
      FINALIZE: state_d = HOLD;
      HOLD:     state_d = HOLD;
      default:  state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  // A dropped sample still completes its handshake; only the sticky flag records it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           overflow <= 1'b0;
    else if (clear)                                    overflow <= 1'b0;
    else if ((ns_acc && ns_full) || (s_acc && s_full)) overflow <= 1'b1;
  end

  // Prototypes move only on the FINALIZE edge, so clear leaves the last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_hv <= '0;
      s_hv  <= '0;
    end else if (state_q == FINALIZE && !clear) begin
      ns_hv <= ns_maj;
      s_hv  <= s_maj;
    end
  end

endmodule

// File: tb/tb_prototype_trainer.sv
// Directed bench for prototype_trainer with DIMENSIONS=8, MAX_SAMPLES=3.
module tb_prototype_trainer;
  import prototype_trainer_pkg::*;

  localparam int D  = 8;
  localparam int MS = 3;
  localparam int CW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          finalize;
  logic          done;
  logic [D-1:0]  ns_hv, s_hv;
  logic [CW-1:0] ns_count, s_count;
  logic          overflow;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;

  prototype_trainer_if #(.DIMENSIONS(D)) smp ();

  prototype_trainer #(.DIMENSIONS(D), .MAX_SAMPLES(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .smp       (smp.slave),
    .clear     (clear),
    .finalize  (finalize),
    .done      (done),
    .ns_hv     (ns_hv),
    .s_hv      (s_hv),
    .ns_count  (ns_count),
    .s_count   (s_count),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D-1:0] hv, input logic label);
    smp.sample_valid = 1'b1;
    smp.sample_hv    = hv;
    smp.sample_label = label;
    tick();
    smp.sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; finalize = 1'b0;
    smp.sample_valid = 1'b0; smp.sample_hv = '0; smp.sample_label = 1'b0;
    #2;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (ns_count !== 2'd0 || s_count !== 2'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", ns_count, s_count); end
    checks++; if (ns_hv !== 8'h00 || s_hv !== 8'h00) begin errors++; $display("FAIL reset_hv: got %h/%h want 00/00", ns_hv, s_hv); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", smp.sample_ready); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_ns_majority();
    send(8'b1100_0011, LABEL_NS);
    send(8'b1010_0011, LABEL_NS);
    send(8'b0110_0001, LABEL_NS);
    checks++; if (ns_count !== 2'd3 || s_count !== 2'd0) begin errors++; $display("FAIL maj_counts: got %0d/%0d want 3/0", ns_count, s_count); end
    finalize = 1'b1;
    tick();
    finalize = 1'b0;
    checks++; if (state_dbg !== FINALIZE) begin errors++; $display("FAIL maj_state1: got %0d want %0d", state_dbg, FINALIZE); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL maj_done_early: got %b want 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL maj_done: got %b want 1", done); end
    checks++; if (ns_hv !== 8'b1110_0011) begin errors++; $display("FAIL maj_ns_hv: got %b want 11100011", ns_hv); end
    checks++; if (s_hv !== 8'h00) begin errors++; $display("FAIL maj_s_hv: got %h want 00", s_hv); end
    checks++; if (ns_count !== 2'd3) begin errors++; $display("FAIL maj_ns_count: got %0d want 3", ns_count); end
  endtask

  task automatic test_clear_hold();
    checks++; if (smp.sample_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", smp.sample_ready); end
    smp.sample_valid = 1'b1; smp.sample_hv = 8'hFF; smp.sample_label = LABEL_S;
    finalize = 1'b1;
    tick();
    smp.sample_valid = 1'b0; finalize = 1'b0;
    checks++; if (s_count !== 2'd0) begin errors++; $display("FAIL hold_no_accept: got %0d want 0", s_count); end
    checks++; if (state_dbg !== HOLD || done !== 1'b1) begin errors++; $display("FAIL hold_state: got %0d/%b want %0d/1", state_dbg, done, HOLD); end
    checks++; if (ns_hv !== 8'b1110_0011) begin errors++; $display("FAIL hold_stable: got %b want 11100011", ns_hv); end
    // Same-cycle sample alongside clear is discarded.
    smp.sample_valid = 1'b1; smp.sample_hv = 8'hFF; smp.sample_label = LABEL_S;
    do_clear();
    smp.sample_valid = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done: got %b want 0", done); end
    checks++; if (ns_count !== 2'd0 || s_count !== 2'd0) begin errors++; $display("FAIL clr_counts: got %0d/%0d want 0/0", ns_count, s_count); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", smp.sample_ready); end
    checks++; if (ns_hv !== 8'b1110_0011 || s_hv !== 8'h00) begin errors++; $display("FAIL clr_hv_kept: got %b/%b want 11100011/00000000", ns_hv, s_hv); end
  endtask

  task automatic test_overflow();
    send(8'b1100_0011, LABEL_NS);
    send(8'b1010_0011, LABEL_NS);
    send(8'b0110_0001, LABEL_NS);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", overflow); end
    checks++; if (smp.sample_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b want 1", smp.sample_ready); end
    send(8'b0001_1100, LABEL_NS);
    checks++; if (ns_count !== 2'd3) begin errors++; $display("FAIL ovf_count: got %0d want 3", ns_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    send(8'h0F, LABEL_S);
    checks++; if (s_count !== 2'd1) begin errors++; $display("FAIL ovf_other_class: got %0d want 1", s_count); end
    finalize = 1'b1; tick(); finalize = 1'b0; tick();
    checks++; if (ns_hv !== 8'b1110_0011) begin errors++; $display("FAIL ovf_ns_hv: got %b want 11100011", ns_hv); end
    checks++; if (s_hv !== 8'h0F) begin errors++; $display("FAIL ovf_s_hv: got %h want 0f", s_hv); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    do_clear();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_tie();
    send(8'b1111_0000, LABEL_S);
    send(8'b0000_1111, LABEL_S);
    finalize = 1'b1; tick(); finalize = 1'b0; tick();
    checks++; if (s_hv !== 8'h00) begin errors++; $display("FAIL tie_s_hv: got %h want 00", s_hv); end
    checks++; if (s_count !== 2'd2) begin errors++; $display("FAIL tie_s_count: got %0d want 2", s_count); end
    checks++; if (ns_hv !== 8'h00) begin errors++; $display("FAIL tie_empty_ns: got %h want 00", ns_hv); end
    do_clear();
  endtask

  task automatic test_same_cycle();
    smp.sample_valid = 1'b1; smp.sample_hv = 8'hFF; smp.sample_label = LABEL_S;
    finalize = 1'b1;
    tick();
    smp.sample_valid = 1'b0; finalize = 1'b0;
    checks++; if (state_dbg !== FINALIZE || s_count !== 2'd1) begin errors++; $display("FAIL same_state: got %0d/%0d want %0d/1", state_dbg, s_count, FINALIZE); end
    tick();
    checks++; if (s_hv !== 8'hFF || done !== 1'b1) begin errors++; $display("FAIL same_s_hv: got %h/%b want ff/1", s_hv, done); end
    checks++; if (ns_hv !== 8'h00) begin errors++; $display("FAIL same_ns_hv: got %h want 00", ns_hv); end
    do_clear();
  endtask

  task automatic test_reset_mid();
    send(8'hFF, LABEL_NS);
    send(8'hFF, LABEL_NS);
    rst = 1'b1;
    #1;
    checks++; if (ns_count !== 2'd0 || s_count !== 2'd0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", ns_count, s_count); end
    checks++; if (ns_hv !== 8'h00 || s_hv !== 8'h00) begin errors++; $display("FAIL rmid_hv: got %h/%h want 00/00", ns_hv, s_hv); end
    checks++; if (done !== 1'b0 || state_dbg !== ACCUM) begin errors++; $display("FAIL rmid_state: got %b/%0d want 0/%0d", done, state_dbg, ACCUM); end
    tick();
    rst = 1'b0;
    finalize = 1'b1; tick(); finalize = 1'b0; tick();
    checks++; if (ns_hv !== 8'h00 || s_hv !== 8'h00 || done !== 1'b1) begin errors++; $display("FAIL rmid_empty_fin: got %h/%h/%b want 00/00/1", ns_hv, s_hv, done); end
    do_clear();
    // Reset while in FINALIZE must not let the pending prototype land.
    send(8'hFF, LABEL_NS);
    finalize = 1'b1; tick(); finalize = 1'b0;
    rst = 1'b1; #1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (ns_hv !== 8'h00 || done !== 1'b0) begin errors++; $display("FAIL rfin_discard: got %h/%b want 00/0", ns_hv, done); end
    rst = 1'b1; #1;
    tick();
    rst = 1'b0;
    // First edge after reset release accepts.
    send(8'h81, LABEL_NS);
    checks++; if (ns_count !== 2'd1) begin errors++; $display("FAIL rfirst_accept: got %0d want 1", ns_count); end
    finalize = 1'b1; tick(); finalize = 1'b0; tick();
    checks++; if (ns_hv !== 8'h81) begin errors++; $display("FAIL rfirst_hv: got %h want 81", ns_hv); end
  endtask

  initial begin
    test_reset();
    test_ns_majority();
    test_clear_hold();
    test_overflow();
    test_tie();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prototype_trainer.md
PROTOTYPE_TRAINER -- requirements
Module: prototype_trainer

Interface
REQ-001 Parameter: DIMENSIONS, default 10000, hypervector width in bits.
REQ-002 Parameter: MAX_SAMPLES, default 255, maximum training samples accepted per class.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: clear  input  1  start new training session; synchronous.
REQ-006 Port: sample_valid  input  1  sample_hv/sample_label valid this cycle.
REQ-007 Port: sample_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: sample_hv  input  DIMENSIONS  encoded training hypervector.
REQ-009 Port: sample_label  input  1  0 = non-seizure class, 1 = seizure class.
REQ-010 Port: finalize  input  1  request majority thresholding of accumulated samples.
REQ-011 Port: done  output  1  prototypes valid for the current session (level).
REQ-012 Port: ns_hv  output  DIMENSIONS  non-seizure prototype; bit encoding directly consumable by the Hamming-distance classifier.
REQ-013 Port: s_hv  output  DIMENSIONS  seizure prototype; same encoding.
REQ-014 Port: ns_count, s_count  output  CW each  samples accepted per class, CW = clog2(MAX_SAMPLES+1).
REQ-015 Port: overflow  output  1  sticky; a sample was dropped because its class was full.

Function
REQ-016 FSM states: ACCUM, FINALIZE, HOLD; sample_ready SHALL equal (state == ACCUM).
REQ-017 Handshake: sample accepted iff sample_valid && sample_ready at a rising edge; one sample per cycle max.
REQ-018 Accepted sample SHALL add sample_hv[i] (0/1) to per-dimension counter i of the labelled class and increment that class's count.
REQ-019 Per-dimension counters SHALL be CW bits; they never wrap.
REQ-020 Sample for a class whose count == MAX_SAMPLES SHALL be dropped (counters and count unchanged) and SHALL set overflow; handshake still completes.
REQ-021 finalize sampled high in ACCUM at edge t: state FINALIZE after t; at edge t+1 ns_hv/s_hv registered, state HOLD, done high; latency 2 edges.
REQ-022 sample_valid and finalize both high in ACCUM: sample SHALL be accepted and included before thresholding.
REQ-023 Threshold: prototype bit i = 1 iff 2*counter_i > class count (strict majority); tie and zero-sample class SHALL yield 0.
REQ-024 finalize outside ACCUM SHALL be ignored.
REQ-025 HOLD: done stays high, prototypes stable, no samples accepted, until clear.
REQ-026 clear (any state) SHALL at next edge zero all counters, counts, overflow, drop done, enter ACCUM; a same-cycle sample or finalize is ignored.
REQ-027 clear SHALL NOT alter ns_hv/s_hv; they change only at a FINALIZE edge.

Reset
REQ-028 rst high SHALL immediately force: state ACCUM, all counters 0, ns_count 0, s_count 0, overflow 0, done 0, ns_hv all 0, s_hv all 0.
REQ-029 Reset mid-accumulation or in FINALIZE SHALL discard the session with no partial prototype update.
REQ-030 First accepting edge is the first edge after rst deasserts.

Structure
REQ-031 State enum and label encoding constants (LABEL_NS = 0, LABEL_S = 1) SHALL live in the shared HDC package, alongside the DIMENSIONS default.
REQ-032 One sub-module, bundle_counter: one class's DIMENSIONS counter array with accumulate, clear and majority-threshold outputs; instantiated twice.

Verification (bench with DIMENSIONS=8, MAX_SAMPLES=3)
REQ-033 Three NS samples 8'b1100_0011, 8'b1010_0011, 8'b0110_0001 then finalize -> ns_hv = 8'b1110_0011, s_hv = 0, done high 2 edges after finalize, ns_count = 3.
REQ-034 Two S samples 8'b1111_0000 and 8'b0000_1111 (tie every bit) then finalize -> s_hv = 8'b0000_0000.
REQ-035 Fourth NS sample after three accepted -> ns_count stays 3, overflow = 1, ns_hv after finalize unchanged by the dropped sample.
REQ-036 sample_valid with S sample 8'hFF and finalize same cycle, empty session -> s_hv = 8'hFF, s_count = 1.
REQ-037 clear in HOLD -> done 0, counts 0, sample_ready 1 next cycle, ns_hv/s_hv keep prior values.
REQ-038 rst pulsed after two samples -> counts 0, prototypes 0, done 0 immediately; subsequent finalize with no samples -> both prototypes 0.
